// File: rtl/reg_scan_reader_pkg.sv
// reg_scan_reader_pkg: shared register-file widths and scan FSM state encoding
package reg_scan_reader_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
endpackage

// File: rtl/reg_scan_reader_if.sv
// reg_scan_reader_if: register-file read port (ra/rd) plus the valid/ready word stream
//   master: drives ra and the out_* stream, samples rd and out_ready
//   slave:  register file + consumer side
interface reg_scan_reader_if
  import reg_scan_reader_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) ();
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  modport master (output ra, out_valid, out_addr, out_data, out_last, input rd, out_ready);
  modport slave (input ra, out_valid, out_addr, out_data, out_last, output rd, out_ready);
endinterface

// File: rtl/reg_scan_reader.sv
// reg_scan_reader: walks register-file addresses FIRST..LAST and streams (addr, data) words
//   clk, rstn  : clock, asynchronous active-low reset
//   start      : scan request, honoured only in IDLE
//   abort      : cancel, wins over every transition
//   bus        : read port (ra/rd) and output stream (out_valid/ready/addr/data/last)
//   busy, done : not-IDLE flag, one-cycle pulse once the LAST word is accepted
module reg_scan_reader
  import reg_scan_reader_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int FIRST  = 0,
  parameter int LAST   = 31
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  reg_scan_reader_if.master  bus,
  output logic               busy,
  output logic               done
);
  localparam logic [ADDR_W-1:0] FA = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] LA = ADDR_W'(LAST);
  state_t            state, state_n;
  logic [ADDR_W-1:0] ra_n, addr_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, last_n, done_n;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    ra_n    = bus.ra;
    valid_n = bus.out_valid;
    addr_n  = bus.out_addr;
    data_n  = bus.out_data;
    last_n  = bus.out_last;
    done_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      ra_n    = FA;
      valid_n = 1'b0;
      last_n  = 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = READ;
          ra_n    = FA;
        end
        // rd has had a full cycle to settle on ra; capture it into the stream word
        READ: begin
          data_n  = bus.rd;
          addr_n  = bus.ra;
          last_n  = bus.ra == LA;
          valid_n = 1'b1;
          state_n = SEND;
        end
        SEND: if (bus.out_ready) begin
          valid_n = 1'b0;
          if (bus.ra == LA) begin
            last_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            ra_n    = bus.ra + 1'b1;
            state_n = READ;
          end
        end
        default: begin
          ra_n    = FA;
          state_n = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      bus.ra        <= FA;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      bus.ra        <= ra_n;
      bus.out_valid <= valid_n;
      bus.out_addr  <= addr_n;
      bus.out_data  <= data_n;
      bus.out_last  <= last_n;
      done          <= done_n;
    end
  end
endmodule

// File: tb/tb_reg_scan_reader.sv
// tb_reg_scan_reader: directed scans of a modelled 32x32 register file through two reader instances
module tb_reg_scan_reader;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        start1 = 1'b0;
  logic        busy, done, busy1, done1;
  logic [31:0] x [32];
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          s;
  always #5 clk = ~clk;
  reg_scan_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  reg_scan_reader_if #(.ADDR_W(5), .DATA_W(32)) bus1 ();
  assign bus.rd  = x[bus.ra];
  assign bus1.rd = x[bus1.ra];
  reg_scan_reader #(.ADDR_W(5), .DATA_W(32), .FIRST(0), .LAST(31)) u0 (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bus(bus), .busy(busy), .done(done)
  );
  reg_scan_reader #(.ADDR_W(5), .DATA_W(32), .FIRST(3), .LAST(3)) u1 (
    .clk(clk), .rstn(rstn), .start(start1), .abort(1'b0), .bus(bus1), .busy(busy1), .done(done1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // wait (bounded) for a word, check it, then let the edge accept it (out_ready assumed high)
  task automatic recv(input int a, input logic [31:0] d, input logic l);
    int n = 0;
    while (!bus.out_valid && n < 8) begin
      tick();
      n++;
    end
    check($sformatf("valid@%0d", a), {31'd0, bus.out_valid}, 32'd1);
    check($sformatf("addr@%0d", a), {27'd0, bus.out_addr}, a);
    check($sformatf("data@%0d", a), bus.out_data, d);
    check($sformatf("last@%0d", a), {31'd0, bus.out_last}, {31'd0, l});
    tick();
  endtask
  initial begin
    bus.out_ready  = 1'b1;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) x[i] = 32'(i * 3);
    #12;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_ra", {27'd0, bus.ra}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_last", {31'd0, bus.out_last}, 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst1_ra", {27'd0, bus1.ra}, 32'd3);
    rstn = 1'b1;
    tick();
    // full scan, ready tied high
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_novalid", {31'd0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 32; i++) recv(i, 32'(i * 3), i == 31);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_done_cyc", 32'(cyc - s), 32'd65);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    // backpressure on address 4, plus a mid-scan write to address 5
    x[4] = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    recv(0, 32'd0, 1'b0);
    recv(1, 32'd3, 1'b0);
    x[5] = 32'd5;
    recv(2, 32'd6, 1'b0);
    recv(3, 32'd9, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t2_hold_addr", {27'd0, bus.out_addr}, 32'd4);
      check("t2_hold_data", bus.out_data, 32'd4);
      tick();
    end
    check("t2_still_addr", {27'd0, bus.out_addr}, 32'd4);
    bus.out_ready = 1'b1;
    tick();
    check("t2_released", {31'd0, bus.out_valid}, 32'd0);
    recv(5, 32'd5, 1'b0);
    for (int i = 6; i < 32; i++) recv(i, 32'(i * 3), i == 31);
    check("t2_done", {31'd0, done}, 32'd1);
    tick();
    // abort during SEND of address 10 with a same-cycle handshake
    start = 1'b1;
    tick();
    start = 1'b0;
    recv(0, 32'd0, 1'b0);
    recv(1, 32'd3, 1'b0);
    recv(2, 32'd6, 1'b0);
    recv(3, 32'd9, 1'b0);
    recv(4, 32'd4, 1'b0);
    recv(5, 32'd5, 1'b0);
    for (int i = 6; i < 10; i++) recv(i, 32'(i * 3), 1'b0);
    tick();
    check("t3_send10", {27'd0, bus.out_addr}, 32'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd0);
    check("t3_ra", {27'd0, bus.ra}, 32'd0);
    tick();
    check("t3_done_late", {31'd0, done}, 32'd0);
    // restart from 0; start held high while busy must be ignored
    start = 1'b1;
    tick();
    recv(0, 32'd0, 1'b0);
    recv(1, 32'd3, 1'b0);
    start = 1'b0;
    recv(2, 32'd6, 1'b0);
    recv(3, 32'd9, 1'b0);
    recv(4, 32'd4, 1'b0);
    recv(5, 32'd5, 1'b0);
    recv(6, 32'd18, 1'b0);
    check("t4_read7_busy", {31'd0, busy}, 32'd1);
    check("t4_read7_ra", {27'd0, bus.ra}, 32'd7);
    // asynchronous reset between edges during READ of address 7
    #2 rstn = 1'b0;
    #1;
    check("t4_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_ra", {27'd0, bus.ra}, 32'd0);
    check("t4_addr", {27'd0, bus.out_addr}, 32'd0);
    check("t4_data", bus.out_data, 32'd0);
    #3 rstn = 1'b1;
    tick();
    tick();
    check("t4_stay_idle", {31'd0, busy}, 32'd0);
    check("t4_stay_novalid", {31'd0, bus.out_valid}, 32'd0);
    // single-word scan FIRST == LAST == 3
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("t5_busy", {31'd0, busy1}, 32'd1);
    tick();
    check("t5_valid", {31'd0, bus1.out_valid}, 32'd1);
    check("t5_addr", {27'd0, bus1.out_addr}, 32'd3);
    check("t5_data", bus1.out_data, 32'd9);
    check("t5_last", {31'd0, bus1.out_last}, 32'd1);
    tick();
    check("t5_done", {31'd0, done1}, 32'd1);
    check("t5_valid_off", {31'd0, bus1.out_valid}, 32'd0);
    check("t5_last_off", {31'd0, bus1.out_last}, 32'd0);
    tick();
    check("t5_idle", {31'd0, busy1}, 32'd0);
    check("t5_done_pulse", {31'd0, done1}, 32'd0);
    x[3] = 32'd3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("t5_data_x3", bus1.out_data, 32'd3);
    tick();
    check("t5_done2", {31'd0, done1}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
